// File: rtl/snake_engine.sv
// snake_engine: grid worm game core with movement, growth, item placement and collision detection.
// Segment 0 is the head; coordinates are 6-bit cell indices on a GRID_W x GRID_H playfield.
module snake_engine #(
    parameter int MAX_SIZE = 100,
    parameter int GRID_W   = 64,
    parameter int GRID_H   = 48
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_start,
    input  logic                  i_tick,
    input  logic                  i_up,
    input  logic                  i_down,
    input  logic                  i_left,
    input  logic                  i_right,
    input  logic [11:0]           i_rand,
    output logic [MAX_SIZE*6-1:0] o_worm_x,
    output logic [MAX_SIZE*6-1:0] o_worm_y,
    output logic [5:0]            o_item_x,
    output logic [5:0]            o_item_y,
    output logic [11:0]           o_size,
    output logic                  o_game_over
);
    typedef enum logic [1:0] {IDLE, RUN, PLACE, OVER} state_t;
    typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;
    typedef logic [MAX_SIZE-1:0][5:0] seg_t;

    function automatic seg_t init_seg(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
        seg_t v;
        v = '0;
        v[0] = a;
        v[1] = b;
        v[2] = c;
        return v;
    endfunction

    localparam seg_t        INIT_X = init_seg(6'd32, 6'd31, 6'd30);
    localparam seg_t        INIT_Y = init_seg(6'd24, 6'd24, 6'd24);
    localparam logic [5:0]  X_MAX  = 6'(GRID_W - 1);
    localparam logic [5:0]  Y_MAX  = 6'(GRID_H - 1);
    localparam logic [11:0] SZ_MAX = 12'(MAX_SIZE);

    state_t      state_q, state_d;
    dir_t        dir_q, dir_d, req_dir;
    seg_t        seg_x_q, seg_x_d, seg_y_q, seg_y_d;
    logic [11:0] size_q, size_d;
    logic [5:0]  item_x_q, item_x_d, item_y_q, item_y_d;
    logic [5:0]  nx, ny, cx, cy;
    logic        req_v, wall_hit, body_hit, cand_hit, cand_ok;

    // The tail cell is excluded from the body check because it vacates on the same move.
    always_comb begin
        nx = dir_q == D_RIGHT ? seg_x_q[0] + 6'd1 : dir_q == D_LEFT ? seg_x_q[0] - 6'd1 : seg_x_q[0];
        ny = dir_q == D_DOWN ? seg_y_q[0] + 6'd1 : dir_q == D_UP ? seg_y_q[0] - 6'd1 : seg_y_q[0];
        cx = i_rand[5:0];
        cy = i_rand[11:6];
        wall_hit = nx == 6'd0 || nx == X_MAX || ny == 6'd0 || ny == Y_MAX;
        body_hit = 1'b0;
        cand_hit = 1'b0;
        for (int j = 0; j < MAX_SIZE; j++) begin
            if (12'(j) + 12'd1 < size_q && seg_x_q[j] == nx && seg_y_q[j] == ny) body_hit = 1'b1;
            if (12'(j) < size_q && seg_x_q[j] == cx && seg_y_q[j] == cy) cand_hit = 1'b1;
        end
        cand_ok = cx != 6'd0 && cx < X_MAX && cy != 6'd0 && cy < Y_MAX && !cand_hit;
    end

    always_comb begin
        req_v    = i_up | i_down | i_left | i_right;
        req_dir  = i_up ? D_UP : i_down ? D_DOWN : i_left ? D_LEFT : D_RIGHT;
        dir_d    = (req_v && req_dir != (dir_q ^ 2'b01)) ? req_dir : dir_q;
        state_d  = state_q;
        seg_x_d  = seg_x_q;
        seg_y_d  = seg_y_q;
        size_d   = size_q;
        item_x_d = item_x_q;
        item_y_d = item_y_q;
        case (state_q)
            IDLE: state_d = i_start ? RUN : IDLE;
            RUN: begin
                if (i_tick) begin
                    if (wall_hit || body_hit) begin
                        state_d = OVER;
                    end else begin
                        seg_x_d = {seg_x_q[MAX_SIZE-2:0], nx};
                        seg_y_d = {seg_y_q[MAX_SIZE-2:0], ny};
                        if (nx == item_x_q && ny == item_y_q) begin
                            size_d  = size_q < SZ_MAX ? size_q + 12'd1 : size_q;
                            state_d = PLACE;
                        end
                    end
                end
            end
            PLACE: begin
                if (cand_ok) begin
                    item_x_d = cx;
                    item_y_d = cy;
                    state_d  = RUN;
                end
            end
            default: begin
                if (i_start) begin
                    state_d  = IDLE;
                    dir_d    = D_RIGHT;
                    seg_x_d  = INIT_X;
                    seg_y_d  = INIT_Y;
                    size_d   = 12'd3;
                    item_x_d = 6'd40;
                    item_y_d = 6'd24;
                end
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_q  <= IDLE;
            dir_q    <= D_RIGHT;
            seg_x_q  <= INIT_X;
            seg_y_q  <= INIT_Y;
            size_q   <= 12'd3;
            item_x_q <= 6'd40;
            item_y_q <= 6'd24;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            seg_x_q  <= seg_x_d;
            seg_y_q  <= seg_y_d;
            size_q   <= size_d;
            item_x_q <= item_x_d;
            item_y_q <= item_y_d;
        end
    end

    // Stale cells beyond the live length stay in the shift register but are hidden here.
    always_comb begin
        o_worm_x = '0;
        o_worm_y = '0;
        for (int j = 0; j < MAX_SIZE; j++) begin
            o_worm_x[j*6+:6] = 12'(j) < size_q ? seg_x_q[j] : 6'd0;
            o_worm_y[j*6+:6] = 12'(j) < size_q ? seg_y_q[j] : 6'd0;
        end
    end

    assign o_item_x    = item_x_q;
    assign o_item_y    = item_y_q;
    assign o_size      = size_q;
    assign o_game_over = state_q == OVER;
endmodule

// File: tb/tb_snake_engine.sv
// tb_snake_engine: directed scenarios for the snake_engine game core.
module tb_snake_engine;
    logic          clk = 1'b0;
    logic          i_Rst = 1'b0;
    logic          i_start = 1'b0, i_tick = 1'b0;
    logic          i_up = 1'b0, i_down = 1'b0, i_left = 1'b0, i_right = 1'b0;
    logic [11:0]   i_rand = 12'd0;
    logic [599:0]  o_worm_x, o_worm_y;
    logic [5:0]    o_item_x, o_item_y;
    logic [11:0]   o_size;
    logic          o_game_over;
    int            total = 0, bad = 0;

    snake_engine dut (
        .i_Clk(clk), .i_Rst(i_Rst), .i_start(i_start), .i_tick(i_tick),
        .i_up(i_up), .i_down(i_down), .i_left(i_left), .i_right(i_right),
        .i_rand(i_rand), .o_worm_x(o_worm_x), .o_worm_y(o_worm_y),
        .o_item_x(o_item_x), .o_item_y(o_item_y), .o_size(o_size), .o_game_over(o_game_over)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] sx(input int j);
        return o_worm_x[j*6+:6];
    endfunction
    function automatic logic [5:0] sy(input int j);
        return o_worm_y[j*6+:6];
    endfunction

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask
    task automatic tick_n(input int n);
        repeat (n) begin
            i_tick = 1'b1;
            clk1();
            i_tick = 1'b0;
        end
    endtask
    task automatic turn(input logic u, input logic d, input logic l, input logic r);
        {i_up, i_down, i_left, i_right} = {u, d, l, r};
        clk1();
        {i_up, i_down, i_left, i_right} = 4'b0;
    endtask
    task automatic pulse_start();
        i_start = 1'b1;
        clk1();
        i_start = 1'b0;
    endtask
    task automatic do_reset();
        i_Rst = 1'b0;
        {i_start, i_tick, i_up, i_down, i_left, i_right} = 6'b0;
        i_rand = 12'd0;
        repeat (2) clk1();
        i_Rst = 1'b1;
        clk1();
    endtask

    task automatic test_reset();
        i_Rst = 1'b0;
        repeat (2) clk1();
        total++; if (o_size !== 12'd3) begin bad++; $display("FAIL reset_size got=%0d want=3", o_size); end
        total++; if ({sx(0), sy(0)} !== {6'd32, 6'd24}) begin bad++; $display("FAIL reset_head got=(%0d,%0d) want=(32,24)", sx(0), sy(0)); end
        total++; if ({sx(1), sx(2)} !== {6'd31, 6'd30}) begin bad++; $display("FAIL reset_body got=%0d,%0d want=31,30", sx(1), sx(2)); end
        total++; if ({sx(3), sy(3)} !== 12'd0) begin bad++; $display("FAIL reset_seg3 got=(%0d,%0d) want=(0,0)", sx(3), sy(3)); end
        total++; if ({o_item_x, o_item_y} !== {6'd40, 6'd24}) begin bad++; $display("FAIL reset_item got=(%0d,%0d) want=(40,24)", o_item_x, o_item_y); end
        total++; if (o_game_over !== 1'b0) begin bad++; $display("FAIL reset_over got=%b want=0", o_game_over); end
        i_Rst = 1'b1;
        clk1();
        tick_n(1);
        total++; if (sx(0) !== 6'd32) begin bad++; $display("FAIL idle_tick head_x got=%0d want=32", sx(0)); end
    endtask

    task automatic test_eat();
        pulse_start();
        tick_n(8);
        total++; if ({sx(0), sy(0)} !== {6'd40, 6'd24}) begin bad++; $display("FAIL eat_head got=(%0d,%0d) want=(40,24)", sx(0), sy(0)); end
        total++; if (o_size !== 12'd4) begin bad++; $display("FAIL eat_size got=%0d want=4", o_size); end
        total++; if ({sx(3), sy(3)} !== {6'd37, 6'd24}) begin bad++; $display("FAIL eat_tail got=(%0d,%0d) want=(37,24)", sx(3), sy(3)); end
        total++; if (sx(1) !== 6'd39) begin bad++; $display("FAIL eat_seg1 got=%0d want=39", sx(1)); end
    endtask

    task automatic test_place();
        i_rand = {6'd5, 6'd0};
        i_tick = 1'b1;
        clk1();
        i_tick = 1'b0;
        total++; if (o_item_x !== 6'd40) begin bad++; $display("FAIL place_wall got=%0d want=40", o_item_x); end
        total++; if (sx(0) !== 6'd40) begin bad++; $display("FAIL place_tick_drop got=%0d want=40", sx(0)); end
        i_rand = {6'd24, 6'd38};
        clk1();
        total++; if ({o_item_x, o_item_y} !== {6'd40, 6'd24}) begin bad++; $display("FAIL place_body got=(%0d,%0d) want=(40,24)", o_item_x, o_item_y); end
        i_rand = {6'd10, 6'd10};
        clk1();
        total++; if ({o_item_x, o_item_y} !== {6'd10, 6'd10}) begin bad++; $display("FAIL place_accept got=(%0d,%0d) want=(10,10)", o_item_x, o_item_y); end
    endtask

    task automatic test_opposite();
        turn(1'b0, 1'b0, 1'b1, 1'b0);
        tick_n(1);
        total++; if ({sx(0), sy(0)} !== {6'd41, 6'd24}) begin bad++; $display("FAIL opposite got=(%0d,%0d) want=(41,24)", sx(0), sy(0)); end
    endtask

    task automatic test_wall();
        tick_n(21);
        total++; if ({sx(0), o_game_over} !== {6'd62, 1'b0}) begin bad++; $display("FAIL wall_edge got=%0d/%b want=62/0", sx(0), o_game_over); end
        tick_n(1);
        total++; if (o_game_over !== 1'b1) begin bad++; $display("FAIL wall_over got=%b want=1", o_game_over); end
        clk1();
        total++; if ({sx(0), sy(0), o_size} !== {6'd62, 6'd24, 12'd4}) begin bad++; $display("FAIL wall_hold got=(%0d,%0d) size=%0d want=(62,24) size=4", sx(0), sy(0), o_size); end
    endtask

    task automatic test_restart();
        pulse_start();
        total++; if ({o_game_over, o_size} !== {1'b0, 12'd3}) begin bad++; $display("FAIL restart got=%b/%0d want=0/3", o_game_over, o_size); end
        total++; if ({sx(0), o_item_x, sx(3)} !== {6'd32, 6'd40, 6'd0}) begin bad++; $display("FAIL restart_layout got=%0d,%0d,%0d want=32,40,0", sx(0), o_item_x, sx(3)); end
        clk1();
        tick_n(1);
        total++; if (sx(0) !== 6'd32) begin bad++; $display("FAIL restart_idle got=%0d want=32", sx(0)); end
    endtask

    task automatic test_self_collision();
        pulse_start();
        tick_n(8);
        i_rand = {6'd24, 6'd41};
        clk1();
        tick_n(1);
        i_rand = {6'd10, 6'd10};
        clk1();
        total++; if ({o_size, sx(0), sx(4)} !== {12'd5, 6'd41, 6'd37}) begin bad++; $display("FAIL grow5 got=%0d head=%0d tail=%0d want=5,41,37", o_size, sx(0), sx(4)); end
        turn(1'b1, 1'b0, 1'b0, 1'b0);
        tick_n(1);
        turn(1'b0, 1'b0, 1'b1, 1'b0);
        tick_n(1);
        total++; if ({sx(0), sy(0)} !== {6'd40, 6'd23}) begin bad++; $display("FAIL turn_path got=(%0d,%0d) want=(40,23)", sx(0), sy(0)); end
        turn(1'b0, 1'b1, 1'b0, 1'b0);
        tick_n(1);
        total++; if ({o_game_over, sx(0), sy(0), o_size} !== {1'b1, 6'd40, 6'd23, 12'd5}) begin bad++; $display("FAIL self_hit got=%b (%0d,%0d) %0d want=1 (40,23) 5", o_game_over, sx(0), sy(0), o_size); end
    endtask

    task automatic test_tail_vacate();
        pulse_start();
        pulse_start();
        tick_n(8);
        clk1();
        turn(1'b1, 1'b0, 1'b0, 1'b0);
        tick_n(1);
        turn(1'b0, 1'b0, 1'b1, 1'b0);
        tick_n(1);
        turn(1'b0, 1'b1, 1'b0, 1'b0);
        tick_n(1);
        total++; if ({o_game_over, sx(0), sy(0)} !== {1'b0, 6'd39, 6'd24}) begin bad++; $display("FAIL tail_vacate got=%b (%0d,%0d) want=0 (39,24)", o_game_over, sx(0), sy(0)); end
        total++; if ({sx(3), sy(3), o_size} !== {6'd40, 6'd24, 12'd4}) begin bad++; $display("FAIL tail_shift got=(%0d,%0d) %0d want=(40,24) 4", sx(3), sy(3), o_size); end
    endtask

    task automatic test_async_reset();
        do_reset();
        pulse_start();
        tick_n(8);
        #2 i_Rst = 1'b0;
        #1;
        total++; if ({o_size, sx(0), sx(1), sx(2), sx(3)} !== {12'd3, 6'd32, 6'd31, 6'd30, 6'd0}) begin bad++; $display("FAIL async_worm got=%0d %0d,%0d,%0d,%0d want=3 32,31,30,0", o_size, sx(0), sx(1), sx(2), sx(3)); end
        total++; if ({o_item_x, o_item_y, o_game_over} !== {6'd40, 6'd24, 1'b0}) begin bad++; $display("FAIL async_item got=(%0d,%0d) %b want=(40,24) 0", o_item_x, o_item_y, o_game_over); end
        i_Rst = 1'b1;
        clk1();
        tick_n(1);
        total++; if (sx(0) !== 6'd32) begin bad++; $display("FAIL async_idle got=%0d want=32", sx(0)); end
    endtask

    initial begin
        test_reset();
        test_eat();
        test_place();
        test_opposite();
        test_wall();
        test_restart();
        test_self_collision();
        test_tail_vacate();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
